// File: rtl/vga_scan_timing.sv
// vga_scan_timing
//   Raster timing generator for the tic-tac-toe display. Divides the board
//   clock down to the pixel rate and runs the x/y scan counters. It also owns
//   the VGA output register: sync and the blank-masked renderer colour are
//   delayed by PIPE pixel ticks so that all three leave the chip aligned.
//
// Ports
//   clk         board clock, rising edge
//   rst         asynchronous reset, active-low
//   x, y        current scan coordinate (0..H_TOTAL-1, 0..V_TOTAL-1)
//   video_on    current x/y lies in the visible area
//   pix_tick    one-clk strobe marking each pixel edge
//   frame_start one-clk strobe on the tick where x/y wrap to 0,0
//   color_in    RGB332 colour from the renderer (PIPE-1 ticks behind x/y)
//   hsync       registered, active-low horizontal sync
//   vsync       registered, active-low vertical sync
//   color_out   registered RGB332 colour, black while blanking
module vga_scan_timing #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int PIPE      = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       pix_tick,
    output logic       frame_start,
    input  logic [7:0] color_in,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] color_out
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // One delay-line entry: active-low syncs plus the visible flag.
    typedef struct packed {
        logic hs;
        logic vs;
        logic vo;
    } stage_t;

    localparam stage_t IDLE_STAGE = '{hs: 1'b1, vs: 1'b1, vo: 1'b0};

    logic [DIV_W-1:0] div;
    stage_t           raw;
    stage_t           into_last;
    stage_t           pipe_q [PIPE];

    // ---------------- pixel-rate divider ----------------
    // With CLK_DIV=1 div stays 0 and the decode below is constantly true.
    assign pix_tick = (div == DIV_W'(CLK_DIV - 1));

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
        end else if (pix_tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // ---------------- scan counters ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
        end else if (pix_tick) begin
            if (x == 10'(H_TOTAL - 1)) begin
                x <= '0;
                y <= (y == 10'(V_TOTAL - 1)) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // ---------------- combinational decodes ----------------
    // NOTE: every field gets a default first so no path leaves a latch.
    always_comb begin
        raw    = IDLE_STAGE;
        raw.vo = (x < 10'(H_VISIBLE)) && (y < 10'(V_VISIBLE));
        if (x >= 10'(H_VISIBLE + H_FRONT) && x <= 10'(H_VISIBLE + H_FRONT + H_SYNC - 1))
            raw.hs = 1'b0;
        if (y >= 10'(V_VISIBLE + V_FRONT) && y <= 10'(V_VISIBLE + V_FRONT + V_SYNC - 1))
            raw.vs = 1'b0;
    end

    assign video_on    = raw.vo;
    assign frame_start = pix_tick && (x == 10'(H_TOTAL - 1)) && (y == 10'(V_TOTAL - 1));

    // The colour register loads on the same tick as the last delay stage, so
    // it must be gated by the visible flag that is about to enter that stage.
    if (PIPE == 1) begin : g_direct
        assign into_last = raw;
    end else begin : g_tap
        assign into_last = pipe_q[PIPE-2];
    end

    // ---------------- output delay line and VGA register ----------------
    // NOTE: the delay line is only a few flops deep and must present "sync
    // inactive, video off" straight out of reset, so every entry is reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE; i++) pipe_q[i] <= IDLE_STAGE;
            color_out <= 8'h00;
        end else if (pix_tick) begin
            pipe_q[0] <= raw;
            for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
            color_out <= into_last.vo ? color_in : 8'h00;
        end
    end

    assign hsync = pipe_q[PIPE-1].hs;
    assign vsync = pipe_q[PIPE-1].vs;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Testbench for vga_scan_timing. Two instances run side by side:
//   dut_a  default 640x480@60 timing, CLK_DIV=2, PIPE=1, random colour input
//   dut_b  miniature raster (35x19), CLK_DIV=1, PIPE=2, colour = x delayed one
//          tick, so whole frames and vsync fit in a short run
// Expected values come from a reference model that derives everything from the
// number of clock edges since reset release using plain div/mod arithmetic.
module tb_vga_scan_timing;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // instance A (defaults)
    logic [9:0] x_a, y_a;
    logic       vo_a, tick_a, fs_a, hs_a, vs_a;
    logic [7:0] cin_a, cout_a;
    // instance B (miniature)
    logic [9:0] x_b, y_b;
    logic       vo_b, tick_b, fs_b, hs_b, vs_b;
    logic [7:0] cin_b, cout_b;

    vga_scan_timing dut_a (
        .clk(clk), .rst(rst), .x(x_a), .y(y_a), .video_on(vo_a),
        .pix_tick(tick_a), .frame_start(fs_a), .color_in(cin_a),
        .hsync(hs_a), .vsync(vs_a), .color_out(cout_a)
    );

    vga_scan_timing #(
        .CLK_DIV(1), .H_VISIBLE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE(2)
    ) dut_b (
        .clk(clk), .rst(rst), .x(x_b), .y(y_b), .video_on(vo_b),
        .pix_tick(tick_b), .frame_start(fs_b), .color_in(cin_b),
        .hsync(hs_b), .vsync(vs_b), .color_out(cout_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        int x, y, col;
        bit vo, tick, fs, hs, vs;
    } exp_t;

    // Expected outputs after c clock edges since reset release. col is the
    // colour input present at the most recent pixel edge.
    function automatic exp_t model(input int hv, hf, hsy, hb, vv, vf, vsy, vb,
                                   input int dv, pp, c, input logic [7:0] col);
        exp_t e;
        int ht, vt, m, n, k, xk, yk;
        bit vok;
        ht = hv + hf + hsy + hb;
        vt = vv + vf + vsy + vb;
        m  = c / dv;                 // pixel edges so far
        n  = m % (ht * vt);
        e.x    = n % ht;
        e.y    = n / ht;
        e.tick = (c % dv) == dv - 1;
        e.vo   = (e.x < hv) && (e.y < vv);
        e.fs   = e.tick && e.x == ht - 1 && e.y == vt - 1;
        if (m < pp) begin
            e.hs = 1; e.vs = 1; e.col = 0;
        end else begin
            k   = (m - pp) % (ht * vt);   // the pixel the outputs describe
            xk  = k % ht;
            yk  = k / ht;
            vok = (xk < hv) && (yk < vv);
            e.hs  = !(xk >= hv + hf && xk < hv + hf + hsy);
            e.vs  = !(yk >= vv + vf && yk < vv + vf + vsy);
            e.col = vok ? int'(col) : 0;
        end
        return e;
    endfunction

    int         c = 0;        // clock edges since reset release
    logic [7:0] last_a = '0;
    logic [7:0] last_b = '0;

    task automatic check_all();
        exp_t ea, eb;
        ea = model(640, 16, 96, 48, 480, 10, 2, 33, 2, 1, c, last_a);
        eb = model(20, 4, 6, 5, 12, 2, 2, 3, 1, 2, c, last_b);
        check("a_x", 32'(x_a), ea.x);
        check("a_y", 32'(y_a), ea.y);
        check("a_video_on", 32'(vo_a), 32'(ea.vo));
        check("a_pix_tick", 32'(tick_a), 32'(ea.tick));
        check("a_frame_start", 32'(fs_a), 32'(ea.fs));
        check("a_hsync", 32'(hs_a), 32'(ea.hs));
        check("a_vsync", 32'(vs_a), 32'(ea.vs));
        check("a_color_out", 32'(cout_a), ea.col);
        check("b_x", 32'(x_b), eb.x);
        check("b_y", 32'(y_b), eb.y);
        check("b_video_on", 32'(vo_b), 32'(eb.vo));
        check("b_pix_tick", 32'(tick_b), 32'(eb.tick));
        check("b_frame_start", 32'(fs_b), 32'(eb.fs));
        check("b_hsync", 32'(hs_b), 32'(eb.hs));
        check("b_vsync", 32'(vs_b), 32'(eb.vs));
        check("b_color_out", 32'(cout_b), eb.col);
    endtask

    // Renderer stand-ins: A gets noise, B gets the x of the previous tick.
    task automatic drive_colors();
        int n;
        cin_a = 8'($urandom);
        if (c == 0) begin
            cin_b = 8'h00;
        end else begin
            n = (c - 1) % (35 * 19);
            cin_b = 8'(n % 35);
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if ((c % 2) == 1) last_a = cin_a;   // A pixel edge
            last_b = cin_b;                      // B ticks every clock
            c++;
            @(negedge clk);
            check_all();
            drive_colors();
        end
    endtask

    task automatic hold_reset();
        c = 0;
        last_a = '0;
        last_b = '0;
        repeat (2) begin
            @(negedge clk);
            check_all();
            drive_colors();
        end
        #2 rst = 1'b1;
    endtask

    initial begin
        cin_a = 8'h00;
        cin_b = 8'h00;
        // power-on reset
        hold_reset();
        // run into the hsync pulse of the first default line, then reset there
        run_cycles(2 * int'($urandom_range(665, 745)));
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        c = 0;
        last_a = '0;
        last_b = '0;
        check_all();                // asynchronous return to reset values
        hold_reset();
        // several default lines and roughly ten miniature frames
        run_cycles(7000 + int'($urandom_range(0, 500)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scan_timing.md
# vga_scan_timing

Upstream raster stage for the tic-tac-toe display. It divides the board clock into a 640x480@60 pixel cadence and drives the `x`/`y` pixel coordinates that the game block uses to decide square, highlight and marker rendering. It also owns the VGA output register. That register samples the renderer's colour, forces black during blanking, and delays `hsync`/`vsync` so that sync and colour leave the chip aligned.

## Interface
Parameters:
- `CLK_DIV`, 2: board clocks per pixel (2 turns 50 MHz into 25 MHz); must be ≥1.
- `H_VISIBLE`, 640; `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48: horizontal timing, in pixels.
- `V_VISIBLE`, 480; `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33: vertical timing, in lines.
- `PIPE`, 1: renderer latency in pixel ticks, from `x`/`y` to a valid `color_in`; legal range 1..4.

Ports:
- `clk`, input, 1: board clock; every flop is clocked on its rising edge.
- `rst`, input, 1: asynchronous reset, active-low.
- `x`, output, 10: current horizontal count, 0..H_TOTAL-1.
- `y`, output, 10: current vertical count, 0..V_TOTAL-1.
- `video_on`, output, 1: high when the current `x`/`y` lies in the visible area.
- `pix_tick`, output, 1: one-`clk` strobe marking each pixel edge.
- `frame_start`, output, 1: one-`clk` strobe on the tick where `x`/`y` wrap to 0,0.
- `color_in`, input, 8: RGB332 colour from the renderer, for the coordinate presented PIPE-1 ticks earlier.
- `hsync`, output, 1: registered, active-low horizontal sync.
- `vsync`, output, 1: registered, active-low vertical sync.
- `color_out`, output, 8: registered RGB332 colour to the DAC/pins.

## Operation
Derived constants:
- H_TOTAL = sum of the four H parameters = 800.
- V_TOTAL = sum of the four V parameters = 525.

Divider:
- `div` counts 0..CLK_DIV-1 and wraps.
- `pix_tick` = (`div` == CLK_DIV-1), decoded combinationally. With CLK_DIV=1 it is constantly high.

Horizontal counter (`x` is the counter register itself):
- On a `pix_tick` edge, `x` increments.
- At H_TOTAL-1 it wraps to 0, and `y` increments.
- `y` wraps to 0 at V_TOTAL-1.
- With no `pix_tick`, both counters hold.

Combinational decodes from the counters:
- `video_on` = (`x` < H_VISIBLE) && (`y` < V_VISIBLE).
- Raw hsync is low for `x` in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
- Raw vsync is low for `y` in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491.
- `frame_start` = `pix_tick` && `x` == H_TOTAL-1 && `y` == V_TOTAL-1.

Output stage (advances only on `pix_tick` edges):
- Raw hsync, raw vsync and `video_on` pass through a PIPE-deep shift register.
- `hsync`/`vsync` are the last stage of that shift register.
- `color_out` <= (delayed `video_on` ? `color_in` : 8'h00). "Delayed" means the value entering the last stage.
- Net effect: `color_out`, `hsync` and `vsync` all describe the same pixel.

Arithmetic:
- Counters are 10-bit unsigned.
- Parameter sums must be ≤1024; out-of-range values are not supported and not checked.

## Timing
Reset (`rst` low, asynchronous):
- `div`=0, `x`=0, `y`=0.
- `hsync`=1, `vsync`=1, `color_out`=0.
- Every delay stage holds "sync inactive, video off".
- Combinational outputs follow from these values: `video_on`=1 and `frame_start`=0. `pix_tick`=0 for CLK_DIV>1; it is 1 when CLK_DIV=1.

Release from reset:
- The first `pix_tick` occurs CLK_DIV `clk` edges after release.
- For CLK_DIV=2: `div` goes 0→1 on the first edge, `pix_tick` is high during the second cycle, and `x` goes 0→1 on the second edge.

Rates and latency:
- One line = H_TOTAL ticks = 1600 `clk`.
- One frame = 420000 ticks = 840000 `clk`.
- `hsync`/`vsync`/`color_out` lag the coordinate counters by exactly PIPE ticks.

Boundary conditions:
- Simultaneous x-wrap and y-wrap: both counters go to 0 on the same edge; `frame_start` is high in the cycle before that edge.
- `color_in` is ignored whenever the delayed `video_on` is 0.
- Reset mid-frame: all state returns to reset values immediately. No partial sync pulse is extended, and the count restarts at 0,0.
- `x`/`y` change only on `pix_tick` edges, so downstream logic sees each coordinate stable for CLK_DIV `clk` cycles.

## Test plan
- **Reset:** drive `rst`=0 mid-line at `x`=300 → `x`,`y`=0, `hsync`=`vsync`=1 and `color_out`=0 asynchronously. First `x` increment on the 2nd `clk` edge after release.
- **Line timing (defaults):**
  - `hsync` period = 1600 `clk`.
  - `hsync` goes low PIPE ticks after `x` reaches 656 and stays low 96 ticks (192 `clk`).
  - `pix_tick` asserts every 2nd `clk`.
- **Frame timing:**
  - `vsync` period = 840000 `clk`, low for 2 lines (3200 `clk`).
  - Exactly one `frame_start` per frame, in the cycle where `x`=799, `y`=524 and `pix_tick`=1.
- **Blanking:** hold `color_in`=8'hFF → `color_out`=8'hFF for exactly 640 ticks per visible line, 8'h00 for the other 160 ticks, and 8'h00 on lines 480..524.
- **Alignment with PIPE=2:**
  - Stimulus: `color_in` = low 8 bits of `x`, delayed one tick.
  - Expected: the first visible `color_out` of each line is 8'h00, and `hsync` falls exactly 656 ticks after that first visible pixel.
- **CLK_DIV=1:** `pix_tick` constantly 1 → line = 800 `clk`, frame = 420000 `clk`.
